// File: rtl/ahb3lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb3lite_sram_slave
//  Brief    : AHB3-Lite memory slave with byte-lane writes, configurable wait
//             states and a two-cycle ERROR response for illegal transfers.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb3lite_sram_slave #(
    parameter int HADDR_WIDTH = 16,
    parameter int HDATA_WIDTH = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [HADDR_WIDTH-1:0] HADDR,
    input  logic [HDATA_WIDTH-1:0] HWDATA,
    input  logic                   HWRITE,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic [3:0]             HPROT,
    input  logic                   HREADY,
    output logic [HDATA_WIDTH-1:0] HRDATA,
    output logic                   HREADYOUT,
    output logic                   HRESP
);

    localparam int c_LANES     = HDATA_WIDTH / 8;
    localparam int c_LANE_BITS = $clog2(c_LANES);
    localparam int c_MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_WAIT = 3'd1;
    localparam logic [2:0] c_XFER = 3'd2;
    localparam logic [2:0] c_ERR1 = 3'd3;
    localparam logic [2:0] c_ERR2 = 3'd4;

    logic [2:0]             r_state_q, w_state_d;
    logic [3:0]             r_wait_q,  w_wait_d;
    logic [HADDR_WIDTH-1:0] r_addr_q,  w_addr_d;
    logic                   r_write_q, w_write_d;
    logic [2:0]             r_size_q,  w_size_d;
    logic [HDATA_WIDTH-1:0] r_rdata_q, w_rdata_d;

    logic [HDATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_size_err;
    logic                   w_align_err;
    logic                   w_range_err;
    logic                   w_bad;
    logic                   w_xfer;
    logic [c_MEM_AW-1:0]    w_word_idx;
    logic [31:0]            w_lane_lo;
    logic [31:0]            w_lane_n;
    logic [c_LANES-1:0]     w_be;
    logic                   w_unused_ok;

    assign w_unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    // A new address phase is only taken while this slave is itself ready,
    // so a stray HREADY during WAIT/ERR1 cannot corrupt the latched transfer.
    assign w_ready  = (r_state_q != c_WAIT) && (r_state_q != c_ERR1);
    assign w_accept = HSEL && HREADY && HTRANS[1] && w_ready;

    assign w_size_err  = HSIZE > 3'(c_LANE_BITS);
    assign w_align_err = (8'(HADDR) & ((8'd1 << HSIZE) - 8'd1)) != 8'd0;
    assign w_range_err = (64'(HADDR) >> c_LANE_BITS) >= 64'(MEM_DEPTH);
    assign w_bad       = w_size_err || w_align_err || w_range_err;

    always_comb begin
        w_state_d = r_state_q;
        w_wait_d  = r_wait_q;
        w_addr_d  = r_addr_q;
        w_write_d = r_write_q;
        w_size_d  = r_size_q;
        case (r_state_q)
            c_WAIT: begin
                if (r_wait_q <= 4'd1) begin
                    w_state_d = c_XFER;
                    w_wait_d  = 4'd0;
                end else begin
                    w_wait_d  = r_wait_q - 4'd1;
                end
            end
            c_ERR1: begin
                w_state_d = c_ERR2;
            end
            default: begin
                if (w_accept) begin
                    w_addr_d  = HADDR;
                    w_write_d = HWRITE;
                    w_size_d  = HSIZE;
                    if (w_bad) begin
                        w_state_d = c_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_d = c_WAIT;
                        w_wait_d  = 4'(WAIT_STATES);
                    end else begin
                        w_state_d = c_XFER;
                    end
                end else begin
                    w_state_d = c_IDLE;
                end
            end
        endcase
    end

    assign w_xfer     = (r_state_q == c_XFER);
    assign w_word_idx = c_MEM_AW'(r_addr_q >> c_LANE_BITS);

    // Combinational array read in the data phase gives write-then-read
    // to the same word the fresh data without a bypass path.
    assign w_rdata_d = (w_xfer && !r_write_q) ? r_mem[w_word_idx] : r_rdata_q;

    always_comb begin
        w_lane_lo = 32'(8'(r_addr_q) & 8'(c_LANES - 1));
        w_lane_n  = 32'd1 << r_size_q;
        w_be      = '0;
        for (int i = 0; i < c_LANES; i++) begin
            w_be[i] = (32'(i) >= w_lane_lo) && (32'(i) < (w_lane_lo + w_lane_n));
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state_q <= c_IDLE;
            r_wait_q  <= 4'd0;
            r_addr_q  <= '0;
            r_write_q <= 1'b0;
            r_size_q  <= 3'd0;
            r_rdata_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wait_q  <= w_wait_d;
            r_addr_q  <= w_addr_d;
            r_write_q <= w_write_d;
            r_size_q  <= w_size_d;
            r_rdata_q <= w_rdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && w_xfer && r_write_q) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = w_rdata_d;
    assign HREADYOUT = w_ready;
    assign HRESP     = (r_state_q == c_ERR1) || (r_state_q == c_ERR2);

endmodule
`default_nettype wire

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
Parametrised AHB3-Lite memory slave, the next generation of the single-byte test memory. Configurable data width, depth and wait states. Adds HSIZE byte-lane writes, a HSEL-gated address phase, and a two-cycle ERROR response for illegal transfers. Sits behind the AHB-Lite decoder/mux as one slave; HREADY comes back from the mux.

Parameters:
HADDR_WIDTH, 16, byte address width
HDATA_WIDTH, 32, data bus width in bits; one of 8, 16, 32, 64
MEM_DEPTH, 1024, number of HDATA_WIDTH-wide words
WAIT_STATES, 0, extra data-phase cycles with HREADYOUT low before completion (0..15)

Ports:
HCLK  in  1  clock; all logic on the rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  HADDR_WIDTH  byte address
HWDATA  in  HDATA_WIDTH  write data (data phase)
HWRITE  in  1  1 = write, 0 = read
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HSIZE  in  3  log2 of transfer bytes
HBURST  in  3  accepted, ignored
HPROT  in  4  accepted, ignored
HREADY  in  1  bus ready from mux
HRDATA  out  HDATA_WIDTH  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, no pending transfer. Memory array is not cleared.
- Address phase accepted only when HSEL & HREADY & HTRANS[1]. On acceptance, latch HADDR, HWRITE and HSIZE.
- HSEL=0, or HTRANS IDLE/BUSY: nothing latched, no memory access. The following data phase is zero-wait OKAY.
- Error checks at acceptance. Any failing check forces the ERR path; memory is never modified on an error.
  - HSIZE > log2(HDATA_WIDTH/8).
  - HADDR not aligned to the transfer size.
  - Word index HADDR >> log2(HDATA_WIDTH/8) >= MEM_DEPTH.
- States:
  - IDLE: no data phase; HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements from WAIT_STATES; at 1, go to XFER.
  - XFER: HREADYOUT=1, HRESP=0; transfer completes.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - On accept, go to WAIT if WAIT_STATES>0, else XFER.
  - On accept with an error, go to ERR1.
  - ERR1 always goes to ERR2.
  - From XFER or ERR2 (HREADYOUT=1): take a new accepted transfer immediately (back-to-back), else go to IDLE.
  - No new address phase is accepted in WAIT or ERR1, because HREADY is low.
- Write: in the XFER cycle, HWDATA byte lanes selected by latched HADDR low bits and HSIZE are written (little-endian). Other lanes are unchanged.
- Read:
  - HRDATA is driven with the full addressed word during the XFER cycle; all lanes are valid, and the master selects its lanes.
  - HRDATA holds its last value otherwise, and is 0 after reset.
  - The array is read in the data phase, so a read immediately following a write to the same word returns the new data (no RAW hazard).
- Reset asserted mid-transfer (WAIT/ERR1/XFER): transfer abandoned, no write, state IDLE next cycle.
- HSEL deasserting during a data phase does not abort it. Completion is governed by the latched transfer.

Test Plan:
- Defaults: write 0xDEADBEEF @0x0010 word, then read @0x0010 back-to-back -> HRDATA=0xDEADBEEF, HREADYOUT=1 each data phase, HRESP=0.
- Byte lanes: word @0x0020 = 0x00000000; write byte 0xA5 @0x0022 (HSIZE=0, HWDATA=0x00A50000) -> word read = 0x00A50000.
- HSEL=0: write NONSEQ 0x55 @0x0030 with HSEL=0, then read with HSEL=1 -> word unchanged (pre-loaded 0x11111111); no HREADYOUT low, HRESP=0 throughout.
- Error: read @0x1000 (word 1024 >= MEM_DEPTH), then halfword write @0x0001 (misaligned) -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory unchanged.
- WAIT_STATES=3: single write then read -> HREADYOUT low exactly 3 cycles per data phase; read returns the written data.
- Reset mid-operation: assert HRESET during WAIT of a write to 0x0040 -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; 0x0040 retains its old value.
